// File: rtl/aes_round_sequencer.sv
// AES round controller: sequences encrypt/decrypt stage handshakes and owns the state register.
// Optional handshake watchdog enabled by defining AES_SEQ_TIMEOUT_EN.
module aes_round_sequencer #(
  parameter int DW  = 128,
  parameter int NR  = 10,
  parameter int KSW = 4,
  parameter int TMO = 64
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           en_i,
  input  logic           mode_i,
  input  logic [DW-1:0]  in_text_i,
  output logic [DW-1:0]  out_text_o,
  output logic           ry_o,
  output logic           busy_o,
  output logic [KSW-1:0] sel_key_o,
  output logic [DW-1:0]  text_o,
  input  logic [DW-1:0]  modified_text_i,
  output logic           add_en_o,
  output logic           sub_en_o,
  output logic           shift_en_o,
  output logic           mix_en_o,
  input  logic           add_ry_i,
  input  logic           sub_ry_i,
  input  logic           shift_ry_i,
  input  logic           mix_ry_i,
  output logic           err_o
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_REQ, S_GAP, S_DONE} state_e;
  typedef enum logic [1:0] {STG_ADD, STG_SUB, STG_SHIFT, STG_MIX} stage_e;

  localparam logic [KSW-1:0] NR_K = KSW'(NR);

  state_e         state_q, state_d;
  stage_e         stage_q, stage_d;
  logic           mode_q, mode_d;
  logic [KSW-1:0] round_q, round_d;
  logic [1:0]     phase_q, phase_d;
  logic [DW-1:0]  text_q, text_d;
  logic [KSW-1:0] sel_key_q, sel_key_d;
  logic [3:0]     en_q, en_d;
  logic           ry_q, ry_d;
  logic           busy_q, busy_d;
  logic           active_ry;
  logic           last_stage;
  logic           timeout;

  // Round 0 is the lone initial ADD; the final round has only three phases, ending in ADD.
  function automatic stage_e stage_of(input logic mode, input logic [KSW-1:0] round,
                                      input logic [1:0] phase);
    stage_e s;
    s = STG_ADD;
    if (round != '0) begin
      if (!mode) begin
        case (phase)
          2'd0:    s = STG_SUB;
          2'd1:    s = STG_SHIFT;
          2'd2:    s = (round == NR_K) ? STG_ADD : STG_MIX;
          default: s = STG_ADD;
        endcase
      end else begin
        case (phase)
          2'd0:    s = STG_SHIFT;
          2'd1:    s = STG_SUB;
          2'd2:    s = STG_ADD;
          default: s = STG_MIX;
        endcase
      end
    end
    return s;
  endfunction

  function automatic logic [KSW-1:0] key_of(input logic mode, input logic [KSW-1:0] round);
    return mode ? (NR_K - round) : round;
  endfunction

  always_comb begin
    case (stage_q)
      STG_ADD:   active_ry = add_ry_i;
      STG_SUB:   active_ry = sub_ry_i;
      STG_SHIFT: active_ry = shift_ry_i;
      default:   active_ry = mix_ry_i;
    endcase
  end

  assign last_stage = (round_q == NR_K) && (phase_q == 2'd2);

`ifdef AES_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TMO + 1);

  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;

  // Counter idles at zero outside REQ, so every REQ entry starts a fresh window.
  always_comb begin
    tmo_d = (state_q == S_REQ) ? tmo_q + 1'b1 : '0;
    err_d = err_q;
    if (timeout)                      err_d = 1'b1;
    else if (state_q == S_IDLE && en_i) err_d = 1'b0;
  end

  assign timeout = (state_q == S_REQ) && !active_ry && (tmo_q == TW'(TMO - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    round_d = round_q;
    phase_d = phase_q;
    text_d  = text_q;
    case (state_q)
      S_IDLE: begin
        if (en_i) begin
          state_d = S_LOAD;
          mode_d  = mode_i;
          text_d  = in_text_i;
          round_d = '0;
          phase_d = '0;
        end
      end
      S_LOAD: state_d = S_REQ;
      S_REQ: begin
        if (active_ry) begin
          text_d  = modified_text_i;
          state_d = S_GAP;
        end else if (timeout) begin
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        if (last_stage) begin
          state_d = S_DONE;
        end else begin
          state_d = S_REQ;
          if (round_q == '0 || phase_q == 2'd3) begin
            round_d = round_q + 1'b1;
            phase_d = '0;
          end else begin
            phase_d = phase_q + 2'd1;
          end
        end
      end
      S_DONE:  if (!en_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are computed from the next state so they appear registered with it.
  always_comb begin
    stage_d   = stage_of(mode_d, round_d, phase_d);
    en_d      = '0;
    sel_key_d = sel_key_q;
    if (state_d == S_REQ) begin
      en_d = 4'b0001 << stage_d;
      if (stage_d == STG_ADD) sel_key_d = key_of(mode_d, round_d);
    end
    ry_d   = (state_d == S_DONE);
    busy_d = (state_d == S_LOAD) || (state_d == S_REQ) || (state_d == S_GAP);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      stage_q   <= STG_ADD;
      mode_q    <= 1'b0;
      round_q   <= '0;
      phase_q   <= '0;
      text_q    <= '0;
      sel_key_q <= '0;
      en_q      <= '0;
      ry_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      mode_q    <= mode_d;
      round_q   <= round_d;
      phase_q   <= phase_d;
      text_q    <= text_d;
      sel_key_q <= sel_key_d;
      en_q      <= en_d;
      ry_q      <= ry_d;
      busy_q    <= busy_d;
    end
  end

  assign {mix_en_o, shift_en_o, sub_en_o, add_en_o} = en_q;
  assign ry_o       = ry_q;
  assign busy_o     = busy_q;
  assign sel_key_o  = sel_key_q;
  assign text_o     = text_q;
  assign out_text_o = text_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench for aes_round_sequencer: vector table plus handshake scoreboard.
// Stage units are modelled as Text+1 with Ry on the second cycle of En.
module tb_aes_round_sequencer;
  localparam int DW  = 128;
  localparam int NR  = 10;
  localparam int KSW = 4;
  localparam int TMO = 64;

  localparam logic [1:0] K_ADD = 2'd0, K_SUB = 2'd1, K_SHIFT = 2'd2, K_MIX = 2'd3;

  logic clk = 1'b0;
  logic rst, en, mode;
  logic [DW-1:0] in_text, out_text, text, modified_text;
  logic ry, busy, err;
  logic [KSW-1:0] sel_key;
  logic add_en, sub_en, shift_en, mix_en;
  logic add_ry, sub_ry, shift_ry, mix_ry;

  logic add_ry_m = 1'b0, sub_ry_m = 1'b0, shift_ry_m = 1'b0, mix_ry_m = 1'b0;
  logic ry_hi = 1'b0, sub_stuck_lo = 1'b0;

  int checks = 0;
  int failures = 0;
  int hs_cnt = 0;

  always #5 clk = ~clk;

  aes_round_sequencer #(.DW(DW), .NR(NR), .KSW(KSW), .TMO(TMO)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode), .in_text_i(in_text),
    .out_text_o(out_text), .ry_o(ry), .busy_o(busy), .sel_key_o(sel_key),
    .text_o(text), .modified_text_i(modified_text),
    .add_en_o(add_en), .sub_en_o(sub_en), .shift_en_o(shift_en), .mix_en_o(mix_en),
    .add_ry_i(add_ry), .sub_ry_i(sub_ry), .shift_ry_i(shift_ry), .mix_ry_i(mix_ry),
    .err_o(err)
  );

  // Stage unit model
  assign modified_text = text + 1'b1;
  always @(posedge clk) begin
    add_ry_m   <= add_en   & ~add_ry_m;
    sub_ry_m   <= sub_en   & ~sub_ry_m;
    shift_ry_m <= shift_en & ~shift_ry_m;
    mix_ry_m   <= mix_en   & ~mix_ry_m;
  end
  assign add_ry   = ry_hi | add_ry_m;
  assign sub_ry   = ry_hi | (sub_ry_m & ~sub_stuck_lo);
  assign shift_ry = ry_hi | shift_ry_m;
  assign mix_ry   = ry_hi | mix_ry_m;

  typedef struct {
    logic [1:0]     stage;
    logic [KSW-1:0] key;
    logic [DW-1:0]  text;
  } hs_t;

  typedef struct {
    logic          mode;
    logic [DW-1:0] in_text;
    bit            ry_hi;
    bit            drop_en;
    int            lat;
    logic [DW-1:0] out;
  } vec_t;

  hs_t  exp_q[$];
  vec_t vecs[5];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected handshake schedule built directly from the encrypt/decrypt orders
  logic [DW-1:0]  sched_base;
  int             sched_n;
  logic [KSW-1:0] sched_k;

  task automatic push_one(input logic [1:0] s, input int key);
    hs_t e;
    if (s == K_ADD) sched_k = KSW'(key);
    e.stage = s;
    e.key   = sched_k;
    e.text  = sched_base + DW'(sched_n);
    exp_q.push_back(e);
    sched_n++;
  endtask

  task automatic push_schedule(input logic m, input logic [DW-1:0] base);
    sched_base = base;
    sched_n    = 0;
    sched_k    = '0;
    if (!m) begin
      push_one(K_ADD, 0);
      for (int r = 1; r <= NR - 1; r++) begin
        push_one(K_SUB, 0); push_one(K_SHIFT, 0); push_one(K_MIX, 0); push_one(K_ADD, r);
      end
      push_one(K_SUB, 0); push_one(K_SHIFT, 0); push_one(K_ADD, NR);
    end else begin
      push_one(K_ADD, NR);
      for (int r = NR - 1; r >= 1; r--) begin
        push_one(K_SHIFT, 0); push_one(K_SUB, 0); push_one(K_ADD, r); push_one(K_MIX, 0);
      end
      push_one(K_SHIFT, 0); push_one(K_SUB, 0); push_one(K_ADD, 0);
    end
  endtask

  // Scoreboard: one handshake per negedge where an enable meets its ready
  logic [3:0] mon_en, mon_ry;
  hs_t        mon_e;
  always @(negedge clk) begin
    if (!rst) begin
      mon_en = {mix_en, shift_en, sub_en, add_en};
      mon_ry = {mix_ry, shift_ry, sub_ry, add_ry};
      if ((mon_en & mon_ry) != 4'b0000) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_handshake: got en=%b expected none at %0t", mon_en, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("hs_stage", mon_en, 4'b0001 << mon_e.stage);
          check("hs_key", sel_key, mon_e.key);
          check("hs_text", text, mon_e.text);
        end
      end
    end
  end

  task automatic check_outputs_zero();
    check("rst_en", {mix_en, shift_en, sub_en, add_en}, 0);
    check("rst_ry", ry, 0);
    check("rst_busy", busy, 0);
    check("rst_sel_key", sel_key, 0);
    check("rst_text", text, 0);
    check("rst_out_text", out_text, 0);
    check("rst_err", err, 0);
  endtask

  task automatic run_op(input vec_t v);
    int cyc;
    @(negedge clk);
    mode    = v.mode;
    in_text = v.in_text;
    ry_hi   = v.ry_hi;
    en      = 1'b1;
    push_schedule(v.mode, v.in_text);
    @(posedge clk); #1;
    cyc = 0;
    while (!ry && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        check("busy_in_op", busy, 1);
        check("err_clear_on_start", err, 0);
      end
      if (cyc == 2) begin
        mode    = ~v.mode;
        in_text = {$urandom, $urandom, $urandom, $urandom};
      end
      if (cyc == 3 && v.drop_en) en = 1'b0;
    end
    check("ry_latency", cyc, v.lat);
    check("out_text", out_text, v.out);
    check("busy_done", busy, 0);
    check("hs_left", exp_q.size(), 0);
    if (!v.drop_en) begin
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1;
        check("ry_hold", ry, 1);
        check("out_hold", out_text, v.out);
      end
      en = 1'b0;
    end
    @(posedge clk); #1;
    check("ry_drop", ry, 0);
    ry_hi = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    int  start;
    bit  ry_seen;

    vecs[0] = '{1'b0, 128'h0,                  1'b0, 1'b0, 121, 128'd40};
    vecs[1] = '{1'b1, 128'h1000,               1'b0, 1'b0, 121, 128'h1028};
    vecs[2] = '{1'b0, {{15{8'hff}}, 8'hf8},    1'b0, 1'b1, 121, 128'h20};
    vecs[3] = '{1'b1, 128'h5,                  1'b1, 1'b0, 81,  128'h2d};
    vecs[4] = '{1'b0, 128'h1234,               1'b1, 1'b0, 81,  128'h125c};

    rst = 1'b1; en = 1'b0; mode = 1'b0; in_text = '0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero();
    rst = 1'b0;

    foreach (vecs[i]) run_op(vecs[i]);

    // Reset in the middle of an operation, then a fresh run
    @(negedge clk);
    mode = 1'b0; in_text = 128'h77; en = 1'b1;
    push_schedule(1'b0, 128'h77);
    start = hs_cnt;
    cyc = 0;
    while (hs_cnt - start < 17 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_hs17", hs_cnt - start, 17);
    rst = 1'b1; en = 1'b0;
    @(posedge clk); #1;
    check_outputs_zero();
    rst = 1'b0;
    ry_seen = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk); #1;
      if (ry) ry_seen = 1'b1;
    end
    check("no_ry_after_rst", ry_seen, 0);
    exp_q.delete();
    run_op(vecs[0]);

`ifdef AES_SEQ_TIMEOUT_EN
    @(negedge clk);
    sub_stuck_lo = 1'b1; mode = 1'b0; in_text = '0; en = 1'b1;
    exp_q.delete();
    push_schedule(1'b0, '0);
    @(posedge clk); #1;
    en = 1'b0;
    cyc = 0;
    while (!sub_en && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("sub_req_seen", sub_en, 1);
    cyc = 0;
    while (!err && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("tmo_cycles", cyc, TMO);
    check("tmo_sub_en", sub_en, 0);
    check("tmo_busy", busy, 0);
    check("tmo_ry", ry, 0);
    repeat (3) @(posedge clk);
    #1;
    check("err_sticky", err, 1);
    sub_stuck_lo = 1'b0;
    exp_q.delete();
    run_op(vecs[1]);
`endif
    check("err_final", err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
